// File: rtl/cal_ctrl.sv
// cal_ctrl: run sequencer for channel-gain calibration.
// Arms on start, aligns to FFT frame boundaries, issues qualified bins to the
// |H| = |Y/X| magnitude pipeline, tracks results in flight, averages the
// returned magnitudes over NFRAMES frames and publishes a saturated 12-bit gain.
module cal_ctrl #(
    parameter int NFFT    = 2048,
    parameter int NFRAMES = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              fft_out_valid,
    input  logic                              sumx_zero,
    input  logic                              dp_result_valid,
    input  logic [12:0]                       dp_result,
    output logic                              bin_valid,
    output logic [$clog2(NFFT)-1:0]           bin_idx,
    output logic [11:0]                       gain,
    output logic                              cal_valid,
    output logic                              busy,
    output logic                              err,
    output logic [$clog2(NFFT*NFRAMES):0]     skip_cnt
);

    localparam int IDX_W  = $clog2(NFFT);
    localparam int TOT_W  = $clog2(NFFT * NFRAMES);
    localparam int SKIP_W = TOT_W + 1;
    localparam int SUM_W  = 13 + TOT_W;
    localparam int FR_W   = $clog2(NFRAMES) + 1;

    localparam logic [IDX_W-1:0] LAST_BIN    = IDX_W'(NFFT - 1);
    localparam logic [FR_W-1:0]  FRAMES      = FR_W'(NFRAMES);
    localparam logic [7:0]       IDLE_LIMIT  = 8'(TIMEOUT - 1);
    localparam logic [8:0]       OUT_MAX     = 9'd511;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FRAME,
        S_CAPTURE,
        S_DRAIN,
        S_UPDATE,
        S_DONE
    } state_e;

    state_e              state_q,       state_d;
    logic                fft_valid_q,   fft_valid_d;
    logic [IDX_W-1:0]    bin_cnt_q,     bin_cnt_d;
    logic [FR_W-1:0]     frame_cnt_q,   frame_cnt_d;
    logic [8:0]          outstanding_q, outstanding_d;
    logic [SUM_W-1:0]    sum_q,         sum_d;
    logic [SKIP_W-1:0]   skip_cnt_q,    skip_cnt_d;
    logic [7:0]          idle_cnt_q,    idle_cnt_d;
    logic                bin_valid_q,   bin_valid_d;
    logic [IDX_W-1:0]    bin_idx_q,     bin_idx_d;
    logic [11:0]         gain_q,        gain_d;
    logic                cal_valid_q,   cal_valid_d;
    logic                busy_q,        busy_d;
    logic                err_q,         err_d;

    logic                frame_start;
    logic                in_run;
    logic                take;
    logic                cap;
    logic                issue;
    logic [FR_W-1:0]     frame_nxt;
    logic [12:0]         avg;

    // A frame begins on the rising edge of the FFT bin strobe.
    assign frame_start = fft_out_valid & ~fft_valid_q;
    // Results are only credited while a run is collecting and something is in flight.
    assign in_run      = (state_q == S_WAIT_FRAME) || (state_q == S_CAPTURE) || (state_q == S_DRAIN);
    assign take        = dp_result_valid && in_run && (outstanding_q != 9'd0);
    assign frame_nxt   = frame_cnt_q + FR_W'(1);
    // Dividing by NFFT*NFRAMES is a plain shift; skipped bins contribute zero.
    assign avg         = sum_q[SUM_W-1 -: 13];

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        // NOTE: every _d starts at its held value so no path leaves a signal unassigned (no latches).
        state_d       = state_q;
        fft_valid_d   = fft_out_valid;
        bin_cnt_d     = bin_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        outstanding_d = outstanding_q;
        sum_d         = sum_q;
        skip_cnt_d    = skip_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        bin_valid_d   = 1'b0;
        bin_idx_d     = bin_idx_q;
        gain_d        = gain_q;
        cal_valid_d   = cal_valid_q;
        err_d         = err_q;
        cap           = 1'b0;
        issue         = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d       = S_WAIT_FRAME;
                    bin_cnt_d     = '0;
                    frame_cnt_d   = '0;
                    outstanding_d = '0;
                    sum_d         = '0;
                    skip_cnt_d    = '0;
                    idle_cnt_d    = '0;
                    err_d         = 1'b0;
                    cal_valid_d   = 1'b0;
                end
            end
            S_WAIT_FRAME: begin
                // The frame-start cycle itself carries bin 0.
                cap = frame_start;
            end
            S_CAPTURE: begin
                if (fft_out_valid) begin
                    cap = 1'b1;
                end else begin
                    // Strobe dropped mid-frame: abandon the run, keep the old gain.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (outstanding_q == 9'd0) begin
                    state_d = S_UPDATE;
                end else if (take) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            S_UPDATE: begin
                gain_d      = (avg > 13'd4095) ? 12'hFFF : avg[11:0];
                cal_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Per-bin qualification and frame bookkeeping.
        if (cap) begin
            if (!sumx_zero) begin
                issue       = 1'b1;
                bin_valid_d = 1'b1;
                bin_idx_d   = bin_cnt_q;
            end else begin
                skip_cnt_d = skip_cnt_q + SKIP_W'(1);
            end
            if (bin_cnt_q == LAST_BIN) begin
                bin_cnt_d   = '0;
                frame_cnt_d = frame_nxt;
                idle_cnt_d  = '0;
                state_d     = (frame_nxt == FRAMES) ? S_DRAIN : S_WAIT_FRAME;
            end else begin
                bin_cnt_d = bin_cnt_q + IDX_W'(1);
                state_d   = S_CAPTURE;
            end
        end

        // Accumulate returned magnitudes and track bins still in flight.
        if (take) begin
            sum_d = sum_q + SUM_W'(dp_result);
        end
        if (issue && !take && (outstanding_q != OUT_MAX)) begin
            outstanding_d = outstanding_q + 9'd1;
        end else if (take && !issue) begin
            outstanding_d = outstanding_q - 9'd1;
        end

        busy_d = (state_d == S_WAIT_FRAME) || (state_d == S_CAPTURE) ||
                 (state_d == S_DRAIN) || (state_d == S_UPDATE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
        if (rst) begin
            state_q       <= S_IDLE;
            fft_valid_q   <= 1'b0;
            bin_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            outstanding_q <= '0;
            sum_q         <= '0;
            skip_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            bin_valid_q   <= 1'b0;
            bin_idx_q     <= '0;
            gain_q        <= '0;
            cal_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            fft_valid_q   <= fft_valid_d;
            bin_cnt_q     <= bin_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            outstanding_q <= outstanding_d;
            sum_q         <= sum_d;
            skip_cnt_q    <= skip_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            bin_valid_q   <= bin_valid_d;
            bin_idx_q     <= bin_idx_d;
            gain_q        <= gain_d;
            cal_valid_q   <= cal_valid_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign bin_valid = bin_valid_q;
    assign bin_idx   = bin_idx_q;
    assign gain      = gain_q;
    assign cal_valid = cal_valid_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign skip_cnt  = skip_cnt_q;

endmodule

// File: tb/tb_cal_ctrl.sv
// Self-checking bench for cal_ctrl: table of whole-run scenarios, hand-written
// abort/reset/timeout sequences, and randomized runs against an averaging model.
module tb_cal_ctrl;

    localparam int NFFT    = 8;
    localparam int NFRAMES = 2;
    localparam int TIMEOUT = 10;
    localparam int SHIFT   = 4;   // log2(NFFT*NFRAMES)

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        fft_out_valid = 1'b0;
    logic        sumx_zero = 1'b0;
    logic        dp_result_valid = 1'b0;
    logic [12:0] dp_result = '0;
    logic        bin_valid;
    logic [2:0]  bin_idx;
    logic [11:0] gain;
    logic        cal_valid;
    logic        busy;
    logic        err;
    logic [4:0]  skip_cnt;

    cal_ctrl #(.NFFT(NFFT), .NFRAMES(NFRAMES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .fft_out_valid(fft_out_valid), .sumx_zero(sumx_zero),
        .dp_result_valid(dp_result_valid), .dp_result(dp_result),
        .bin_valid(bin_valid), .bin_idx(bin_idx), .gain(gain),
        .cal_valid(cal_valid), .busy(busy), .err(err), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] mask;
        int         val;
        int         gap;
        int         lat;
        int         exp_gain;
        int         exp_skip;
        int         exp_bins;
    } vec_t;

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     rq_time[$];
    int     rq_val[$];
    int     exp_idx[$];
    int     bins_seen = 0;
    int     idx_bad = 0;
    int     drop_n = -1;
    int     lat = 5;
    int     fixed_val = 100;
    int     last_sched = 0;
    int     last_res_cyc = -1000;
    int     last_bin_cyc = 0;
    longint ret_sum = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: observe issued bins, schedule their results, drive due results.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bin_valid === 1'b1) begin
            if (exp_idx.size() == 0) begin
                idx_bad++;
            end else begin
                if (bin_idx !== 3'(exp_idx[0])) idx_bad++;
                void'(exp_idx.pop_front());
            end
            if (bins_seen != drop_n) begin
                int t;
                t = cyc + lat;
                if (t <= last_sched) t = last_sched + 1;
                last_sched = t;
                rq_time.push_back(t);
                rq_val.push_back(fixed_val >= 0 ? fixed_val : int'($urandom_range(0, 8191)));
            end
            bins_seen++;
        end
        dp_result_valid = 1'b0;
        dp_result       = '0;
        if (rq_time.size() > 0 && rq_time[0] == cyc) begin
            dp_result_valid = 1'b1;
            dp_result       = 13'(rq_val[0]);
            ret_sum        += rq_val[0];
            last_res_cyc    = cyc;
            void'(rq_time.pop_front());
            void'(rq_val.pop_front());
        end
    endtask

    task automatic drive_frame(input logic [7:0] mask, input int nbins, input int start_at);
        for (int b = 0; b < nbins; b++) begin
            fft_out_valid = 1'b1;
            sumx_zero     = mask[b];
            start         = (b == start_at);
            if (!mask[b]) exp_idx.push_back(b);
            last_bin_cyc = cyc;
            tick();
        end
        fft_out_valid = 1'b0;
        sumx_zero     = 1'b0;
        start         = 1'b0;
    endtask

    task automatic begin_run(input int l, input int v, input int d);
        rq_time.delete();
        rq_val.delete();
        exp_idx.delete();
        bins_seen    = 0;
        idx_bad      = 0;
        drop_n       = d;
        lat          = l;
        fixed_val    = v;
        last_sched   = 0;
        ret_sum      = 0;
        last_res_cyc = -1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic wait_end(output int t);
        t = -1;
        for (int i = 0; i < 300; i++) begin
            if (cal_valid === 1'b1 || err === 1'b1) begin
                t = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic do_run(input logic [7:0] m0, input logic [7:0] m1, input int gap,
                          input int l, input int v, input int d, input int mid_start,
                          output int done);
        begin_run(l, v, d);
        drive_frame(m0, NFFT, -1);
        repeat (gap) tick();
        drive_frame(m1, NFFT, mid_start);
        wait_end(done);
    endtask

    function automatic int ref_time();
        return (last_res_cyc > last_bin_cyc) ? last_res_cyc : last_bin_cyc;
    endfunction

    task automatic check_run(input string nm, input int eg, input int es, input int eb, input int done);
        check({nm, " gain"},      gain,      eg);
        check({nm, " cal_valid"}, cal_valid, 1);
        check({nm, " err"},       err,       0);
        check({nm, " busy"},      busy,      0);
        check({nm, " skip_cnt"},  skip_cnt,  es);
        check({nm, " bins"},      bins_seen, eb);
        check({nm, " bin_idx"},   idx_bad,   0);
        check({nm, " latency"},   done,      ref_time() + 3);
    endtask

    vec_t   vecs[8];
    int     done;
    int     g_prev;
    int     gcyc;
    longint avg;

    initial begin
        vecs[0] = '{mask: 8'h00, val: 100,  gap: 3, lat: 5, exp_gain: 100,  exp_skip: 0,  exp_bins: 16};
        vecs[1] = '{mask: 8'h24, val: 100,  gap: 3, lat: 5, exp_gain: 75,   exp_skip: 4,  exp_bins: 12};
        vecs[2] = '{mask: 8'h00, val: 8191, gap: 1, lat: 8, exp_gain: 4095, exp_skip: 0,  exp_bins: 16};
        vecs[3] = '{mask: 8'hFF, val: 100,  gap: 2, lat: 5, exp_gain: 0,    exp_skip: 16, exp_bins: 0};
        vecs[4] = '{mask: 8'h0F, val: 8191, gap: 2, lat: 3, exp_gain: 4095, exp_skip: 8,  exp_bins: 8};
        vecs[5] = '{mask: 8'h01, val: 4096, gap: 2, lat: 4, exp_gain: 3584, exp_skip: 2,  exp_bins: 14};
        vecs[6] = '{mask: 8'h00, val: 4096, gap: 2, lat: 2, exp_gain: 4095, exp_skip: 0,  exp_bins: 16};
        vecs[7] = '{mask: 8'h00, val: 4095, gap: 2, lat: 2, exp_gain: 4095, exp_skip: 0,  exp_bins: 16};

        // Reset state.
        repeat (2) tick();
        rst = 1'b0;
        check("reset bin_valid", bin_valid, 0);
        check("reset bin_idx",   bin_idx,   0);
        check("reset gain",      gain,      0);
        check("reset cal_valid", cal_valid, 0);
        check("reset busy",      busy,      0);
        check("reset err",       err,       0);
        check("reset skip_cnt",  skip_cnt,  0);

        // Table-driven whole runs (same bin mask in both frames).
        g_prev = 0;
        foreach (vecs[i]) begin
            do_run(vecs[i].mask, vecs[i].mask, vecs[i].gap, vecs[i].lat, vecs[i].val, -1, -1, done);
            check_run($sformatf("vec%0d", i), vecs[i].exp_gain, vecs[i].exp_skip, vecs[i].exp_bins, done);
            g_prev = vecs[i].exp_gain;
        end

        // Mid-frame gap: strobe drops after bin 3.
        begin_run(5, 100, -1);
        check("arm busy", busy, 1);
        check("arm cal_valid dropped", cal_valid, 0);
        drive_frame(8'h00, 4, -1);
        gcyc = cyc;
        check("gap err not yet", err, 0);
        tick();
        check("gap err cycle", cyc, gcyc + 1);
        check("gap err",       err,       1);
        check("gap busy",      busy,      0);
        check("gap cal_valid", cal_valid, 0);
        check("gap gain kept", gain,      g_prev);
        repeat (8) tick();
        check("gap gain after late results", gain, g_prev);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart clears err", err,  0);
        check("restart busy",       busy, 1);

        // Reset mid-CAPTURE.
        tick();
        for (int b = 0; b < 3; b++) begin
            fft_out_valid = 1'b1;
            sumx_zero     = (b == 1);
            tick();
        end
        check("pre-rst skip_cnt", skip_cnt, 1);
        check("pre-rst busy",     busy,     1);
        fft_out_valid = 1'b1;
        sumx_zero     = 1'b0;
        rst           = 1'b1;
        tick();
        rst           = 1'b0;
        fft_out_valid = 1'b0;
        check("rst bin_valid", bin_valid, 0);
        check("rst bin_idx",   bin_idx,   0);
        check("rst gain",      gain,      0);
        check("rst cal_valid", cal_valid, 0);
        check("rst busy",      busy,      0);
        check("rst err",       err,       0);
        check("rst skip_cnt",  skip_cnt,  0);
        repeat (8) tick();
        check("rst no partial gain", gain, 0);

        // Start pulse during CAPTURE of frame 1 must be ignored.
        do_run(8'h24, 8'h00, 2, 5, 100, -1, 3, done);
        check_run("ignored start", 87, 2, 14, done);
        g_prev = 87;

        // Drain timeout: the last issued bin never returns.
        do_run(8'h00, 8'h00, 2, 5, 100, 15, -1, done);
        check("timeout cycle",     done,      ref_time() + TIMEOUT + 1);
        check("timeout err",       err,       1);
        check("timeout busy",      busy,      0);
        check("timeout cal_valid", cal_valid, 0);
        check("timeout gain kept", gain,      g_prev);

        // Randomized runs against the averaging model.
        for (int r = 0; r < 6; r++) begin
            logic [7:0] m0;
            logic [7:0] m1;
            int         es;
            int         eg;
            m0 = 8'($urandom);
            m1 = 8'($urandom);
            es = $countones(m0) + $countones(m1);
            do_run(m0, m1, $urandom_range(1, 4), $urandom_range(1, 8), -1, -1, -1, done);
            avg = ret_sum >> SHIFT;
            eg  = (avg > 4095) ? 4095 : int'(avg);
            check_run($sformatf("rand%0d", r), eg, es, NFFT * NFRAMES - es, done);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
